div_issue_seq: RTL and testbench

//  Request/response front end for the multi-cycle CompDivider datapath. Accepts a divide request

---
 rtl/div_issue_seq.sv | 139 +++++++++++++
 tb/tb_div_issue_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_seq.sv
// Request/response sequencer wrapped around the multi-cycle unsigned divider.
// It converts signed operands to magnitudes, restores the result signs, and handles divide-by-zero and divider timeout.
module div_issue_seq #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_signed,
    input  logic [WIDTH-1:0] req_dividend,
    input  logic [WIDTH-1:0] req_divisor,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_quotient,
    output logic [WIDTH-1:0] rsp_remainder,
    output logic             rsp_dz,
    output logic             rsp_timeout,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    output logic             div_run,
    input  logic             div_ready,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state;
    logic             sq;
    logic             sr;
    logic [CW-1:0]    wait_cnt;
    logic [WIDTH-1:0] q_raw;
    logic [WIDTH-1:0] r_raw;
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    always_comb begin
        neg_a = req_signed & req_dividend[WIDTH-1];
        neg_b = req_signed & req_divisor[WIDTH-1];
        mag_a = neg_a ? (-req_dividend) : req_dividend;
        mag_b = neg_b ? (-req_divisor)  : req_divisor;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_dz        <= 1'b0;
            rsp_timeout   <= 1'b0;
            div_dividend  <= '0;
            div_divisor   <= '0;
            div_run       <= 1'b0;
            sq            <= 1'b0;
            sr            <= 1'b0;
            wait_cnt      <= '0;
            q_raw         <= '0;
            r_raw         <= '0;
        end else begin
            div_run <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        sq          <= neg_a ^ neg_b;
                        sr          <= neg_a;
                        rsp_dz      <= 1'b0;
                        rsp_timeout <= 1'b0;
                        req_ready   <= 1'b0;
                        if (req_divisor == '0) begin
                            rsp_quotient  <= '1;
                            rsp_remainder <= req_dividend;
                            rsp_dz        <= 1'b1;
                            rsp_valid     <= 1'b1;
                            state         <= S_DONE;
                        end else begin
                            div_dividend <= mag_a;
                            div_divisor  <= mag_b;
                            div_run      <= 1'b1;
                            state        <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // wait_cnt==0 marks the first WAIT cycle, where div_ready may be left over from the previous op
                    if (wait_cnt != '0 && div_ready) begin
                        q_raw <= div_quotient;
                        r_raw <= div_remainder;
                        state <= S_FIX;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        rsp_quotient  <= '0;
                        rsp_remainder <= '0;
                        rsp_timeout   <= 1'b1;
                        rsp_valid     <= 1'b1;
                        state         <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_FIX: begin
                    rsp_quotient  <= sq ? (-q_raw) : q_raw;
                    rsp_remainder <= sr ? (-r_raw) : r_raw;
                    rsp_valid     <= 1'b1;
                    state         <= S_DONE;
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_issue_seq.sv
// Directed bench for div_issue_seq. A small behavioural divider answers div_run after a programmable number of WAIT cycles.
module tb_div_issue_seq;

    localparam int unsigned W  = 32;
    localparam int unsigned TO = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic         req_signed;
    logic [W-1:0] req_dividend;
    logic [W-1:0] req_divisor;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_quotient;
    logic [W-1:0] rsp_remainder;
    logic         rsp_dz;
    logic         rsp_timeout;
    logic [W-1:0] div_dividend;
    logic [W-1:0] div_divisor;
    logic         div_run;
    logic         div_ready;
    logic [W-1:0] div_quotient;
    logic [W-1:0] div_remainder;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // divider model controls
    int   dm_delay = 0;
    logic dm_stuck = 1'b0;
    int   wc       = 0;
    bit   busy     = 1'b0;
    int   run_cnt  = 0;

    div_issue_seq #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_signed   (req_signed),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_quotient (rsp_quotient),
        .rsp_remainder(rsp_remainder),
        .rsp_dz       (rsp_dz),
        .rsp_timeout  (rsp_timeout),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_run      (div_run),
        .div_ready    (div_ready),
        .div_quotient (div_quotient),
        .div_remainder(div_remainder)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (div_run) run_cnt++;
    end

    // div_ready rises in the dm_delay-th WAIT cycle; dm_stuck forces it high all the time
    always @(negedge clk) begin
        if (!reset) begin
            busy      = 1'b0;
            wc        = 0;
            div_ready = dm_stuck;
        end else if (div_run) begin
            busy      = 1'b1;
            wc        = 0;
            div_ready = dm_stuck;
        end else if (busy) begin
            wc++;
            if (wc == dm_delay) begin
                div_ready = 1'b1;
                busy      = 1'b0;
            end else begin
                div_ready = dm_stuck;
            end
        end else begin
            div_ready = dm_stuck;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] dq, input logic [W-1:0] dr, input int delay, input logic stuck,
                          input logic [W-1:0] ea, input logic [W-1:0] eb,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edz, input logic eto, input int elat);
        int r0;
        int lat;
        r0            = run_cnt;
        div_quotient  = dq;
        div_remainder = dr;
        dm_delay      = delay;
        dm_stuck      = stuck;
        req_signed    = sg;
        req_dividend  = a;
        req_divisor   = b;
        req_valid     = 1'b1;
        check({tag, ".req_ready_idle"}, req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        if (!edz) begin
            check({tag, ".div_run"}, div_run, 1);
            check({tag, ".div_dividend"}, div_dividend, ea);
            check({tag, ".div_divisor"}, div_divisor, eb);
        end
        while (!rsp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, lat, elat);
        check({tag, ".quotient"}, rsp_quotient, eq);
        check({tag, ".remainder"}, rsp_remainder, er);
        check({tag, ".dz"}, rsp_dz, edz);
        check({tag, ".timeout"}, rsp_timeout, eto);
        check({tag, ".req_ready_done"}, req_ready, 0);
        check({tag, ".run_pulses"}, run_cnt - r0, edz ? 0 : 1);
    endtask

    task automatic consume(input string tag, input int hold, input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic edz, input logic eto);
        rsp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            check({tag, ".hold_valid"}, rsp_valid, 1);
            check({tag, ".hold_q"}, rsp_quotient, eq);
            check({tag, ".hold_r"}, rsp_remainder, er);
            check({tag, ".hold_flags"}, {rsp_dz, rsp_timeout}, {edz, eto});
            check({tag, ".hold_req_ready"}, req_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, ".post_valid"}, rsp_valid, 0);
        check({tag, ".post_req_ready"}, req_ready, 1);
        check({tag, ".post_q"}, rsp_quotient, eq);
        check({tag, ".post_flags"}, {rsp_dz, rsp_timeout}, {edz, eto});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        reset         = 1'b0;
        req_valid     = 1'b0;
        req_signed    = 1'b0;
        req_dividend  = '0;
        req_divisor   = '0;
        rsp_ready     = 1'b0;
        div_quotient  = '0;
        div_remainder = '0;
        repeat (2) @(negedge clk);
        check("rst.req_ready", req_ready, 1);
        check("rst.rsp_valid", rsp_valid, 0);
        check("rst.rsp_data", {rsp_quotient, rsp_remainder}, 0);
        check("rst.flags", {rsp_dz, rsp_timeout}, 0);
        check("rst.div_data", {div_dividend, div_divisor}, 0);
        check("rst.div_run", div_run, 0);
        reset = 1'b1;
        @(negedge clk);

        // unsigned 100/7, consumer stalls 10 cycles
        run_op("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 2, 1'b0,
               32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 5);
        consume("u100_7", 10, 32'd14, 32'd2, 1'b0, 1'b0);

        // signed -7/2
        run_op("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'd3, 32'd1, 2, 1'b0,
               32'd7, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 5);
        consume("s-7_2", 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // signed 7/-2, slower divider
        run_op("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd3, 32'd1, 4, 1'b0,
               32'd7, 32'd2, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, 7);
        consume("s7_-2", 0, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);

        // unsigned with top bit set: no magnitude conversion
        run_op("u_big", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 3, 1'b0,
               32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b0, 6);
        consume("u_big", 0, 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b0);

        // MIN / -1 overflow
        run_op("s_min", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 2, 1'b0,
               32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 5);
        consume("s_min", 0, 32'h8000_0000, 32'd0, 1'b0, 1'b0);

        // divide by zero
        run_op("dz", 1'b1, 32'h0000_1234, 32'd0, 32'd0, 32'd0, 2, 1'b0,
               32'd0, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1'b0, 1);
        consume("dz", 3, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1'b0);

        // div_ready stuck high: ignored in first WAIT cycle, captured on the second
        run_op("stuck", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 0, 1'b1,
               32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1'b0, 5);
        consume("stuck", 0, 32'd10, 32'd0, 1'b0, 1'b0);

        // divider never answers
        run_op("tmo", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 0, 1'b0,
               32'd9, 32'd3, 32'd0, 32'd0, 1'b0, 1'b1, 2 + TO);
        consume("tmo", 2, 32'd0, 32'd0, 1'b0, 1'b1);

        // reset pulsed in WAIT
        dm_delay     = 5;
        dm_stuck     = 1'b0;
        req_signed   = 1'b0;
        req_dividend = 32'd40;
        req_divisor  = 32'd4;
        req_valid    = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("rstmid.req_ready", req_ready, 1);
        check("rstmid.rsp_valid", rsp_valid, 0);
        check("rstmid.div_run", div_run, 0);
        check("rstmid.flags", {rsp_dz, rsp_timeout}, 0);
        @(negedge clk);
        reset = 1'b1;
        r0 = run_cnt;
        repeat (10) @(negedge clk);
        check("rstmid.no_run", run_cnt - r0, 0);
        check("rstmid.idle_valid", rsp_valid, 0);
        check("rstmid.idle_ready", req_ready, 1);

        // recovery after reset
        run_op("recov", 1'b1, 32'hFFFF_FFD8, 32'd4, 32'd10, 32'd0, 2, 1'b0,
               32'd40, 32'd4, 32'hFFFF_FFF6, 32'd0, 1'b0, 1'b0, 5);
        consume("recov", 0, 32'hFFFF_FFF6, 32'd0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
